pfd_sync: RTL and testbench

- Clocked phase-frequency detector for the software PLL.
- Compares rising edges of the reference `link` against the locally generated `vco` square wave, both oversampled on `clk`.
- Produces classic tri-state UP/DN pulses plus a 2-bit `setting` summary consumed by the frequency-update logic.
- `setting[0]` is high while a phase-error pulse is active; `setting[1]` gives its direction. The PLL measures the high time of `setting[0]` in `clk` cycles as the phase error.

---
 rtl/pfd_sync_if.sv | 21 ++
 rtl/pfd_sync.sv | 84 ++++++++
 tb/tb_pfd_sync.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pfd_sync_if.sv
// Handshake bundle for the clocked phase-frequency detector.
// master drives link/vco and observes setting/up/dn/upb/dnb; slave is the PFD.
interface pfd_sync_if;
  logic       link;
  logic       vco;
  logic [1:0] setting;
  logic       up;
  logic       dn;
  logic       upb;
  logic       dnb;

  modport master (
    output link, vco,
    input  setting, up, dn, upb, dnb
  );

  modport slave (
    input  link, vco,
    output setting, up, dn, upb, dnb
  );
endinterface

// File: rtl/pfd_sync.sv
// Clocked tri-state PFD: synchronizes link/vco, detects rising edges and
// drives registered up/dn/upb/dnb plus setting = {direction, pulse active}.
// Ports: clk, rst (async, active-high), bus (pfd_sync_if.slave).
module pfd_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  pfd_sync_if.slave  bus
);

  logic [SYNC_STAGES-1:0] link_sync_q;
  logic [SYNC_STAGES-1:0] vco_sync_q;
  logic                   link_hist_q;
  logic                   vco_hist_q;

  logic up_q, dn_q, act_q, dir_q;
  logic upb_q, dnb_q;
  logic up_d, dn_d, dir_d;

  logic lr, vr;

  assign lr = link_sync_q[SYNC_STAGES-1] & ~link_hist_q;
  assign vr = vco_sync_q[SYNC_STAGES-1] & ~vco_hist_q;

  // direction only moves when a new pulse starts, so it stays valid
  // through the falling edge of the active flag
  always_comb begin
    up_d  = up_q;
    dn_d  = dn_q;
    dir_d = dir_q;
    if (lr && vr) begin
      up_d = 1'b0;
      dn_d = 1'b0;
    end else if (lr) begin
      if (dn_q) begin
        dn_d = 1'b0;
      end else if (!up_q) begin
        up_d  = 1'b1;
        dir_d = 1'b1;
      end
    end else if (vr) begin
      if (up_q) begin
        up_d = 1'b0;
      end else if (!dn_q) begin
        dn_d  = 1'b1;
        dir_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_sync_q <= '0;
      vco_sync_q  <= '0;
      link_hist_q <= 1'b0;
      vco_hist_q  <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      upb_q       <= 1'b1;
      dnb_q       <= 1'b1;
      act_q       <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      link_sync_q <= {link_sync_q[SYNC_STAGES-2:0], bus.link};
      vco_sync_q  <= {vco_sync_q[SYNC_STAGES-2:0], bus.vco};
      link_hist_q <= link_sync_q[SYNC_STAGES-1];
      vco_hist_q  <= vco_sync_q[SYNC_STAGES-1];
      up_q        <= up_d;
      dn_q        <= dn_d;
      upb_q       <= ~up_d;
      dnb_q       <= ~dn_d;
      act_q       <= up_d | dn_d;
      dir_q       <= dir_d;
    end
  end

  assign bus.up      = up_q;
  assign bus.dn      = dn_q;
  assign bus.upb     = upb_q;
  assign bus.dnb     = dnb_q;
  assign bus.setting = {dir_q, act_q};

endmodule

// File: tb/tb_pfd_sync.sv
// Directed self-checking bench for pfd_sync (SYNC_STAGES = 2).
// Drives link/vco #1 after each rising edge and checks there as well.
module tb_pfd_sync;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  pfd_sync_if bus ();

  pfd_sync #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // packs {setting, upb, dnb, up, dn}
  function automatic logic [7:0] outs();
    return {2'b00, bus.setting, bus.upb, bus.dnb, bus.up, bus.dn};
  endfunction

  localparam logic [7:0] IDLE0 = 8'b00_00_11_00;
  localparam logic [7:0] IDLE1 = 8'b00_10_11_00;
  localparam logic [7:0] UPON  = 8'b00_11_01_10;
  localparam logic [7:0] DNON  = 8'b00_01_10_01;

  int hi, bad;

  initial begin
    rst      = 1'b1;
    bus.link = 1'b0;
    bus.vco  = 1'b0;
    #2;
    chk("reset_async", outs(), IDLE0);
    bus.link = 1'b1; bus.vco = 1'b1;
    tick(1);
    chk("reset_hold1", outs(), IDLE0);
    bus.link = 1'b0;
    tick(1);
    chk("reset_hold2", outs(), IDLE0);
    bus.link = 1'b1; bus.vco = 1'b0;
    tick(1);
    chk("reset_hold3", outs(), IDLE0);

    // link already high at release -> one up pulse start
    rst = 1'b0;
    tick(2);
    chk("rel_lat", outs(), IDLE0);
    tick(1);
    chk("rel_up", outs(), UPON);
    bus.vco = 1'b1;
    tick(3);
    chk("rel_end", outs(), IDLE1);
    bus.link = 1'b0; bus.vco = 1'b0;
    tick(4);

    // link leads by 15 sampled cycles
    bus.link = 1'b1;
    hi = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (bus.up) begin
        hi++;
        if (outs() !== UPON) bad++;
      end
      if (bus.dn) bad++;
      if (k == 2) chk("ll_lat", outs(), IDLE1);
      if (k == 3) chk("ll_start", outs(), UPON);
      if (k == 6) bus.link = 1'b0;
      if (k == 15) bus.vco = 1'b1;
    end
    chk("ll_width", 8'(hi), 8'd15);
    chk("ll_shape", 8'(bad), 8'd0);
    chk("ll_after", outs(), IDLE1);
    bus.vco = 1'b0;
    tick(4);

    // simultaneous edges: no pulse, direction held
    bus.link = 1'b1; bus.vco = 1'b1;
    bad = 0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      if (outs() !== IDLE1) bad++;
    end
    chk("sim_nopulse", 8'(bad), 8'd0);
    chk("sim_dir", 8'(bus.setting), 8'b10);
    bus.link = 1'b0; bus.vco = 1'b0;
    tick(4);

    // vco leads by 8 sampled cycles
    bus.vco = 1'b1;
    hi = 0; bad = 0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (bus.dn) begin
        hi++;
        if (outs() !== DNON) bad++;
      end
      if (bus.up) bad++;
      if (k == 3) chk("vl_start", outs(), DNON);
      if (k == 8) bus.link = 1'b1;
    end
    chk("vl_width", 8'(hi), 8'd8);
    chk("vl_shape", 8'(bad), 8'd0);
    chk("vl_after", outs(), IDLE0);
    bus.link = 1'b0; bus.vco = 1'b0;
    tick(4);

    // frequency detect: link edges at N, N+20, N+40, vco low
    bus.link = 1'b1;
    bad = 0;
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      if (k >= 3 && outs() !== UPON) bad++;
      if (k < 3 && outs() !== IDLE0) bad++;
      if (k == 5 || k == 25 || k == 45) bus.link = 1'b0;
      if (k == 20 || k == 40) bus.link = 1'b1;
    end
    chk("fd_hold", 8'(bad), 8'd0);
    bus.vco = 1'b1;
    tick(2);
    chk("fd_lat", outs(), UPON);
    tick(1);
    chk("fd_clear", outs(), IDLE1);
    bus.link = 1'b0; bus.vco = 1'b0;
    tick(4);

    // vco pulse to move direction to 0 before the reset test
    bus.vco = 1'b1;
    tick(3);
    chk("pre_dn", outs(), DNON);
    bus.link = 1'b1;
    tick(3);
    chk("pre_end", outs(), IDLE0);
    bus.link = 1'b0; bus.vco = 1'b0;
    tick(4);

    // reset mid-pulse clears without a clock edge
    bus.link = 1'b1;
    tick(3);
    chk("rm_up", outs(), UPON);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_async", outs(), IDLE0);
    bus.link = 1'b0;
    tick(3);
    chk("rm_hold", outs(), IDLE0);
    rst = 1'b0;
    tick(3);
    chk("rm_idle", outs(), IDLE0);
    bus.link = 1'b1;
    tick(2);
    chk("rm_lat", outs(), IDLE0);
    tick(1);
    chk("rm_fresh", outs(), UPON);
    tick(10);
    chk("rm_static", outs(), UPON);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
